instr_fetch_unit: RTL and testbench

- Upstream fetch stage feeding the main decoder.
- Holds the program counter and requests instructions from an instruction memory with variable latency.
- Registers the returned word and presents it, with its opcode field, to the decode/control stage under a valid/ready handshake.
- Applies branch/jump redirects from the execute stage and discards stale fetches.

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC holder and single-outstanding instruction fetcher.
// It issues one request per instruction, registers the returned word and
// presents it to decode under a valid/ready handshake. Redirects from
// execute replace the PC in any state. A fetch that was already granted
// when the redirect arrived is marked as killed, and its response is dropped.
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction memory
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  // redirect from execute
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  // decode handshake
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [6:0]      op_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);

  typedef enum logic [1:0] {FETCH, WAIT_RSP, VALID} state_t;

  // Held instruction. The word reads as NOP whenever vld is low, so decode
  // sees a harmless instruction even if it ignores valid.
  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] word;
  } rsp_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  rsp_t            rsp_q, rsp_d;

  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc_plus4;

  // Targets are forced word-aligned. The increment wraps naturally at 2^XLEN.
  assign redirect_pc = {redirect_target_i[XLEN-1:2], 2'b00};
  assign pc_plus4    = pc_q + XLEN'(4);

  // State, PC, kill flag and held instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      rsp_q   <= '{vld: 1'b0, word: NOP_INSTR};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      rsp_q   <= rsp_d;
    end
  end

  // Next-state logic: redirect beats consume, and stale responses are dropped
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    rsp_d   = '{vld: 1'b0, word: NOP_INSTR};
    unique case (state_q)
      FETCH: begin
        // The address is pc_q, and it only moves on a redirect. If a redirect
        // coincides with a grant, the in-flight fetch targets the old PC.
        if (imem_gnt) begin
          state_d = WAIT_RSP;
          kill_d  = redirect_i;
        end
        if (redirect_i) pc_d = redirect_pc;
      end
      WAIT_RSP: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || redirect_i) begin
            state_d = FETCH;
          end else begin
            state_d = VALID;
            rsp_d   = '{vld: 1'b1, word: imem_rdata};
          end
        end else if (redirect_i) begin
          kill_d = 1'b1;
        end
        if (redirect_i) pc_d = redirect_pc;
      end
      VALID: begin
        rsp_d = rsp_q;
        if (redirect_i) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
          rsp_d   = '{vld: 1'b0, word: NOP_INSTR};
        end else if (instr_ready_i) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
          rsp_d   = '{vld: 1'b0, word: NOP_INSTR};
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // The request is gated by reset so that it drops at assertion rather than
  // at the next edge.
  assign imem_req      = rst_n && (state_q == FETCH);
  assign imem_addr     = pc_q;
  assign instr_valid_o = rsp_q.vld;
  assign instr_o       = rsp_q.word;
  assign op_o          = rsp_q.word[6:0];
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. The main fetch path is driven from a
// vector table. Backpressure, redirects, wrap and mid-transaction reset use
// hand-written sequences. Inputs change 1ns after the rising edge, and
// outputs are sampled at the same point.
module tb_instr_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_target_i = '0;
  logic        instr_valid_o, instr_ready_i = 1'b0;
  logic [31:0] instr_o, pc_o, pc_plus4_o;
  logic [6:0]  op_o;

  int tests  = 0;
  int failed = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .op_o(op_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic [6:0]  op;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Wait, with a bound, for a request, then check the address it carries.
  task automatic wait_req(input logic [31:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", 32'(imem_req), 32'd1);
    chk("req_addr", imem_addr, exp_addr);
  endtask

  // Grant one fetch, answer it on the next cycle, then check the held instruction.
  task automatic do_fetch(input logic [31:0] word, input logic [31:0] exp_pc);
    wait_req(exp_pc);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wait_no_req", 32'(imem_req), 32'd0);
    chk("wait_no_vld", 32'(instr_valid_o), 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    chk("vld", 32'(instr_valid_o), 32'd1);
    chk("instr", instr_o, word);
    chk("op", 32'(op_o), 32'(word[6:0]));
    chk("pc", pc_o, exp_pc);
    chk("pc4", pc_plus4_o, exp_pc + 32'd4);
  endtask

  // Consume the held instruction and check that the PC advances by 4.
  task automatic consume(input logic [31:0] exp_pc);
    instr_ready_i = 1'b1;
    step();
    instr_ready_i = 1'b0;
    chk("cons_vld", 32'(instr_valid_o), 32'd0);
    chk("cons_nop", instr_o, NOP);
    chk("cons_pc", pc_o, exp_pc + 32'd4);
    chk("cons_req", 32'(imem_req), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] held_i, held_p;
    vecs[0] = '{32'h0011_2023, 32'd0,  7'b0100011};
    vecs[1] = '{32'h0020_81B3, 32'd4,  7'b0110011};
    vecs[2] = '{32'h0020_8463, 32'd8,  7'b1100011};
    vecs[3] = '{32'h0010_8093, 32'd12, 7'b0010011};
    vecs[4] = '{32'h0080_006F, 32'd16, 7'b1101111};

    // Reset state
    step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_vld", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_op", 32'(op_o), 32'h13);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_pc4", pc_plus4_o, 32'd4);
    rst_n = 1'b1;
    #1;

    // First fetch: a load word at address 0
    do_fetch(32'h0000_2083, 32'd0);
    chk("first_op", 32'(op_o), 32'h03);
    consume(32'd0);
    chk("next_addr", imem_addr, 32'd4);

    // Vector table: one instruction per opcode class, at consecutive PCs
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_fetch(vecs[i].word, vecs[i].pc);
      chk("vec_op", 32'(op_o), 32'(vecs[i].op));
      consume(vecs[i].pc);
    end

    // Backpressure: the held instruction stays put and no fetch is issued
    do_fetch(32'h0040_0113, 32'd20);
    held_i = instr_o;
    held_p = pc_o;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_instr", instr_o, 32'h0040_0113);
      chk("bp_pc", pc_o, 32'd20);
      chk("bp_req", 32'(imem_req), 32'd0);
      chk("bp_vld", 32'(instr_valid_o), 32'd1);
    end
    chk("bp_same", instr_o, held_i);
    chk("bp_same_pc", pc_o, held_p);
    consume(32'd20);
    chk("bp_next", imem_addr, 32'd24);

    // Redirect during WAIT_RSP: the late response is discarded
    wait_req(32'd24);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect_i = 1'b1;
    redirect_target_i = 32'h0000_0100;
    step();
    redirect_i = 1'b0;
    chk("rw_req", 32'(imem_req), 32'd0);
    chk("rw_pc", pc_o, 32'h100);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("rw_vld", 32'(instr_valid_o), 32'd0);
    chk("rw_instr", instr_o, NOP);
    chk("rw_req2", 32'(imem_req), 32'd1);
    chk("rw_addr", imem_addr, 32'h100);
    // rvalid outside WAIT_RSP is ignored
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("stray_vld", 32'(instr_valid_o), 32'd0);
    chk("stray_req", 32'(imem_req), 32'd1);

    // Redirect in VALID beats consume, and the target is aligned down
    do_fetch(32'h0000_0033, 32'h100);
    instr_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_target_i = 32'h0000_0042;
    step();
    instr_ready_i = 1'b0;
    redirect_i = 1'b0;
    chk("rv_vld", 32'(instr_valid_o), 32'd0);
    chk("rv_addr", imem_addr, 32'h40);
    chk("rv_req", 32'(imem_req), 32'd1);

    // Redirect in FETCH without a grant: the request moves to the new PC
    redirect_i = 1'b1;
    redirect_target_i = 32'h0000_0103;
    step();
    redirect_i = 1'b0;
    chk("rf_addr", imem_addr, 32'h100);
    chk("rf_req", 32'(imem_req), 32'd1);

    // Redirect coinciding with a grant: the response is killed
    imem_gnt = 1'b1;
    redirect_i = 1'b1;
    redirect_target_i = 32'h0000_0200;
    step();
    imem_gnt = 1'b0;
    redirect_i = 1'b0;
    chk("rg_req", 32'(imem_req), 32'd0);
    chk("rg_pc", pc_o, 32'h200);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    step();
    imem_rvalid = 1'b0;
    chk("rg_vld", 32'(instr_valid_o), 32'd0);
    chk("rg_addr", imem_addr, 32'h200);

    // PC wrap at the top of the address space
    redirect_i = 1'b1;
    redirect_target_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    chk("wrap_pc4", pc_plus4_o, 32'd0);
    do_fetch(32'h0000_0013, 32'hFFFF_FFFC);
    consume(32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'd0);

    // Reset asserted during WAIT_RSP, followed by a late response
    redirect_i = 1'b1;
    redirect_target_i = 32'h0000_0080;
    step();
    redirect_i = 1'b0;
    wait_req(32'h80);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_req", 32'(imem_req), 32'd0);
    chk("mr_pc", pc_o, 32'd0);
    chk("mr_vld", 32'(instr_valid_o), 32'd0);
    chk("mr_instr", instr_o, NOP);
    step();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("mr_late_vld", 32'(instr_valid_o), 32'd0);
    chk("mr_late_req", 32'(imem_req), 32'd1);
    chk("mr_late_addr", imem_addr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
